// File: rtl/step_motor_ctrl.sv
// 4-phase stepper driver with full/half-step sequencing, programmable step
// period, continuous run and counted moves, signed position tracking and
// optional coil hold while idle.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   enable            continuous-run request (level)
//   dir               0 = forward (phase index +), 1 = reverse (phase index -)
//   half_step         1 = half-step sequencing, 0 = full-step
//   hold              1 = keep current phase energised when idle
//   period            clocks per step (0 and 1 both mean 1)
//   cmd_valid/ready   counted-move handshake, cmd_steps = step count
//   abort             end a move or a run at the next clock
//   pos_clear         synchronous position clear
//   busy, done        not idle / one-cycle move-complete pulse
//   step_pulse        one-cycle pulse per step event
//   position          signed two's-complement step position
//   motor_out         coil drive {A,B,nA,nB}
module step_motor_ctrl #(
    parameter int unsigned DIV_W = 26,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned POS_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             dir,
    input  logic             half_step,
    input  logic             hold,
    input  logic [DIV_W-1:0] period,
    input  logic             cmd_valid,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic             cmd_ready,
    input  logic             abort,
    input  logic             pos_clear,
    output logic             busy,
    output logic             done,
    output logic             step_pulse,
    output logic [POS_W-1:0] position,
    output logic [3:0]       motor_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MOVE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [DIV_W-1:0] timer;
    logic [CNT_W-1:0] remaining;

    // Coil pattern for each half-step phase index.
    function automatic logic [3:0] phase(input logic [2:0] i);
        case (i)
            3'd0:    phase = 4'b1100;
            3'd1:    phase = 4'b1000;
            3'd2:    phase = 4'b1001;
            3'd3:    phase = 4'b0001;
            3'd4:    phase = 4'b0011;
            3'd5:    phase = 4'b0010;
            3'd6:    phase = 4'b0110;
            default: phase = 4'b0100;
        endcase
    endfunction

    logic [DIV_W-1:0] period_eff;
    logic             step_hit;
    logic [2:0]       stride;
    logic [2:0]       idx_next;
    logic [POS_W-1:0] pos_step;
    logic [3:0]       idle_drive;

    // Period 0 is clamped to 1 so the step condition is always reachable.
    assign period_eff = (period == '0) ? DIV_W'(1) : period;
    assign step_hit   = (timer == period_eff - DIV_W'(1));

    // An odd index in full-step mode takes a single half step to realign.
    assign stride     = (half_step || idx[0]) ? 3'd1 : 3'd2;
    assign idx_next   = dir ? (idx - stride) : (idx + stride);
    assign pos_step   = dir ? (position - POS_W'(1)) : (position + POS_W'(1));
    assign idle_drive = hold ? phase(idx) : 4'b0000;

    // Follows enable within the cycle so a raised enable blocks acceptance
    // of a command in that same cycle.
    assign cmd_ready  = (state == IDLE) && !enable;

    // Sequencer, timer, position and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            timer      <= '0;
            remaining  <= '0;
            position   <= '0;
            motor_out  <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            done       <= 1'b0;
            step_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    timer     <= '0;
                    motor_out <= idle_drive;
                    if (enable) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        motor_out <= phase(idx);
                    end else if (cmd_valid) begin
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= MOVE;
                            busy      <= 1'b1;
                            remaining <= cmd_steps;
                            motor_out <= phase(idx);
                        end
                    end
                end
                RUN, MOVE: begin
                    // Stop requests take priority over a coincident step.
                    if (abort || (state == RUN && !enable)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        timer     <= '0;
                        motor_out <= idle_drive;
                    end else if (step_hit) begin
                        timer      <= '0;
                        idx        <= idx_next;
                        step_pulse <= 1'b1;
                        position   <= pos_step;
                        motor_out  <= phase(idx_next);
                        if (state == MOVE) begin
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        timer     <= timer + DIV_W'(1);
                        motor_out <= phase(idx);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    timer <= '0;
                end
            endcase
            // Clear wins over any step update to position this cycle.
            if (pos_clear) begin
                position <= '0;
            end
        end
    end

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Self-checking bench for step_motor_ctrl: hand-computed move vectors,
// directed multi-cycle sequences (run, abort, enable/cmd priority, position
// clear, position wrap on a narrow instance) and randomized moves checked
// against a phase-index/position reference model.
module tb_step_motor_ctrl;

    localparam int unsigned DIV_W  = 26;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned POS_W  = 32;
    localparam int unsigned WPOS_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable, dir, half_step, hold, cmd_valid, abort, pos_clear;
    logic [DIV_W-1:0] period;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_ready, busy, done, step_pulse;
    logic [POS_W-1:0] position;
    logic [3:0]       motor_out;

    logic              w_enable;
    logic              w_cmd_ready, w_busy, w_done, w_step_pulse;
    logic [WPOS_W-1:0] w_position;
    logic [3:0]        w_motor_out;

    always #5 clk = ~clk;

    step_motor_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .dir(dir),
        .half_step(half_step), .hold(hold), .period(period),
        .cmd_valid(cmd_valid), .cmd_steps(cmd_steps), .cmd_ready(cmd_ready),
        .abort(abort), .pos_clear(pos_clear), .busy(busy), .done(done),
        .step_pulse(step_pulse), .position(position), .motor_out(motor_out)
    );

    // Narrow position counter so the signed wrap point is reachable quickly.
    step_motor_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(WPOS_W)) u_dut_w (
        .clk(clk), .reset_n(reset_n), .enable(w_enable), .dir(1'b0),
        .half_step(1'b0), .hold(1'b0), .period(DIV_W'(1)),
        .cmd_valid(1'b0), .cmd_steps(CNT_W'(0)), .cmd_ready(w_cmd_ready),
        .abort(1'b0), .pos_clear(1'b0), .busy(w_busy), .done(w_done),
        .step_pulse(w_step_pulse), .position(w_position), .motor_out(w_motor_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]       tbl [8];
    int               m_idx;
    logic [POS_W-1:0] m_pos;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase index walks mod 8, full steps are 2 except when
    // realigning from an odd index; position moves by one per step.
    task automatic model_step(input logic d, input logic h);
        int delta;
        delta = (h || (m_idx % 2 == 1)) ? 1 : 2;
        m_idx = d ? (m_idx + 8 - delta) % 8 : (m_idx + delta) % 8;
        m_pos = d ? (m_pos - POS_W'(1)) : (m_pos + POS_W'(1));
    endtask

    task automatic do_move(input int n, input int p, input logic d, input logic h,
                           input logic hd, output int lat, output int npulse,
                           output logic [POS_W-1:0] pos_d, output logic [3:0] mot_d);
        int k;
        bit got;
        @(negedge clk);
        chk("ready_idle", 64'(cmd_ready), 64'(1));
        dir = d; half_step = h; hold = hd;
        period = DIV_W'(p); cmd_steps = CNT_W'(n); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (n > 0) chk("ready_busy", 64'(cmd_ready), 64'(0));
        k = 1; got = 1'b0; npulse = 0; lat = -1; pos_d = '0; mot_d = '0;
        while (!got && k < 4000) begin
            if (step_pulse) begin
                npulse++;
                model_step(d, h);
                chk("step_motor", 64'(motor_out), 64'(tbl[m_idx]));
                chk("step_pos", 64'(position), 64'(m_pos));
            end
            if (done) begin
                got = 1'b1; lat = k - 1; pos_d = position; mot_d = motor_out;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("done_seen", 64'(got), 64'(1));
        @(negedge clk);
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_pulse", 64'(step_pulse), 64'(0));
        chk("post_done", 64'(done), 64'(0));
        chk("post_motor", 64'(motor_out), 64'(hd ? tbl[m_idx] : 4'b0000));
    endtask

    typedef struct {
        int               n;
        int               p;
        logic             d;
        logic             h;
        int               exp_lat;
        logic [POS_W-1:0] exp_pos;
        logic [3:0]       exp_mot;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, np, cnt, bad;
        bit found;
        logic [POS_W-1:0] pd, p0;
        logic [3:0] md;

        tbl = '{4'b1100, 4'b1000, 4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100};
        m_idx = 0; m_pos = '0;

        // Hand-computed moves from reset (index 0, position 0), hold off.
        vecs[0] = '{3, 4, 1'b0, 1'b0, 12, 32'd3,        4'b0110}; // 0->2->4->6
        vecs[1] = '{3, 1, 1'b1, 1'b0,  3, 32'd0,        4'b1100}; // 6->4->2->0
        vecs[2] = '{4, 2, 1'b1, 1'b1,  8, 32'hFFFFFFFC, 4'b0011}; // 0->7->6->5->4
        vecs[3] = '{1, 3, 1'b0, 1'b1,  3, 32'hFFFFFFFD, 4'b0010}; // 4->5
        vecs[4] = '{2, 0, 1'b0, 1'b0,  2, 32'hFFFFFFFF, 4'b1100}; // 5->6->0, period 0
        vecs[5] = '{1, 5, 1'b1, 1'b0,  5, 32'hFFFFFFFE, 4'b0110}; // 0->6
        vecs[6] = '{1, 2, 1'b1, 1'b1,  2, 32'hFFFFFFFD, 4'b0010}; // 6->5
        vecs[7] = '{1, 1, 1'b1, 1'b0,  1, 32'hFFFFFFFC, 4'b0011}; // 5->4 realign
        vecs[8] = '{0, 3, 1'b0, 1'b0,  0, 32'hFFFFFFFC, 4'b0000}; // zero-step move

        reset_n = 1'b0; enable = 1'b0; dir = 1'b0; half_step = 1'b0; hold = 1'b0;
        cmd_valid = 1'b0; abort = 1'b0; pos_clear = 1'b0; w_enable = 1'b0;
        period = DIV_W'(1); cmd_steps = '0;

        repeat (2) @(negedge clk);
        chk("rst_motor", 64'(motor_out), 64'(0));
        chk("rst_pos", 64'(position), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pulse", 64'(step_pulse), 64'(0));
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_move(vecs[i].n, vecs[i].p, vecs[i].d, vecs[i].h, 1'b0, lat, np, pd, md);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_pulses", i), 64'(np), 64'(vecs[i].n));
            chk($sformatf("vec%0d_pos", i), 64'(pd), 64'(vecs[i].exp_pos));
            chk($sformatf("vec%0d_motor", i), 64'(md), 64'(vecs[i].exp_mot));
        end

        // Continuous run at period 1 with hold, then release enable.
        @(negedge clk);
        dir = 1'b0; half_step = 1'b0; hold = 1'b1; period = DIV_W'(1); enable = 1'b1;
        #1 chk("ready_enable", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        chk("run_busy", 64'(busy), 64'(1));
        chk("run_first", 64'(step_pulse), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            model_step(1'b0, 1'b0);
            chk("run_pulse", 64'(step_pulse), 64'(1));
            chk("run_pos", 64'(position), 64'(m_pos));
            chk("run_motor", 64'(motor_out), 64'(tbl[m_idx]));
        end
        enable = 1'b0;
        @(negedge clk);
        chk("run_stop_busy", 64'(busy), 64'(0));
        chk("run_stop_pulse", 64'(step_pulse), 64'(0));
        chk("run_stop_pos", 64'(position), 64'(m_pos));
        chk("run_hold_motor", 64'(motor_out), 64'(tbl[m_idx]));

        // enable and cmd_valid together: run wins, command is dropped.
        @(negedge clk);
        hold = 1'b0; period = DIV_W'(3); cmd_steps = CNT_W'(5); cmd_valid = 1'b1; enable = 1'b1;
        @(negedge clk);
        chk("prio_busy", 64'(busy), 64'(1));
        cmd_valid = 1'b0; enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || done || step_pulse) bad++;
        end
        chk("prio_no_move", 64'(bad), 64'(0));
        chk("prio_pos", 64'(position), 64'(m_pos));

        // Abort coincident with the third step event of a 10-step move.
        @(negedge clk);
        dir = 1'b0; half_step = 1'b0; period = DIV_W'(4); cmd_steps = CNT_W'(10); cmd_valid = 1'b1;
        p0 = m_pos;
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 0;
        for (int k = 1; k < 12; k++) begin
            if (step_pulse) begin cnt++; model_step(1'b0, 1'b0); end
            @(negedge clk);
        end
        chk("abort_pre_pulses", 64'(cnt), 64'(2));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_pulse", 64'(step_pulse), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_pos", 64'(position), 64'(p0 + POS_W'(2)));
        @(negedge clk);
        chk("abort_done_after", 64'(done), 64'(0));

        // pos_clear coincident with a step: position 0, index still advances.
        @(negedge clk);
        hold = 1'b1; period = DIV_W'(1); enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_step(1'b0, 1'b0);
        chk("clr_pre_pulse", 64'(step_pulse), 64'(1));
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0; enable = 1'b0;
        model_step(1'b0, 1'b0);
        m_pos = '0;
        chk("clr_pulse", 64'(step_pulse), 64'(1));
        chk("clr_pos", 64'(position), 64'(0));
        chk("clr_motor", 64'(motor_out), 64'(tbl[m_idx]));
        @(negedge clk);
        chk("clr_idle_pos", 64'(position), 64'(0));

        // Signed wrap from max positive to min negative.
        w_enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (w_position == 8'h7F) found = 1'b1;
        end
        chk("wrap_reach_max", 64'(found), 64'(1));
        @(negedge clk);
        chk("wrap_pos", 64'(w_position), 64'(8'h80));
        chk("wrap_pulse", 64'(w_step_pulse), 64'(1));
        w_enable = 1'b0;

        // Randomized moves against the reference model.
        for (int i = 0; i < 25; i++) begin
            int rn, rp;
            logic rd, rh, rhd;
            rn  = int'($urandom_range(1, 6));
            rp  = int'($urandom_range(0, 5));
            rd  = 1'($urandom_range(0, 1));
            rh  = 1'($urandom_range(0, 1));
            rhd = 1'($urandom_range(0, 1));
            do_move(rn, rp, rd, rh, rhd, lat, np, pd, md);
            chk("rnd_lat", 64'(lat), 64'(rn * ((rp == 0) ? 1 : rp)));
            chk("rnd_pulses", 64'(np), 64'(rn));
            chk("rnd_pos", 64'(pd), 64'(m_pos));
            chk("rnd_motor", 64'(md), 64'(tbl[m_idx]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
